// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT sequencer and IF/ID pipeline register.
// Optional feature: define IFETCH_MISALIGN_TRAP_EN to trap (and halt) on misaligned redirect targets.
//
// state | meaning
// BOOT  | one cycle after reset, PC held at RESET_PC, IF/ID invalid
// RUN   | fetching, one instruction per non-stalled cycle
// HALT  | fetch stopped, PC frozen, IF/ID invalid; exit only by reset
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        halt_req,
   output logic [31:0] pc_addr,
   input  logic [31:0] instr_rd,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic        if_valid,
   output logic        halted
`ifdef IFETCH_MISALIGN_TRAP_EN
   ,
   output logic        misalign_trap
`endif
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] br_pc;

   assign pc_plus4 = pc + 32'd4;
   // Redirect targets are word aligned; low bits are dropped on load.
   assign br_pc    = br_target & ~32'd3;
   assign pc_addr  = pc;
   assign halted   = (state == ST_HALT);

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic trap_q;
   logic misaligned;

   assign misaligned    = (br_target[1:0] != 2'b00);
   assign misalign_trap = trap_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_BOOT;
         pc          <= RESET_PC;
         if_instr    <= 32'd0;
         if_pc       <= 32'd0;
         if_pc_plus4 <= 32'd0;
         if_valid    <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
         trap_q      <= 1'b0;
`endif
      end else begin
`ifdef IFETCH_MISALIGN_TRAP_EN
         trap_q <= 1'b0;
`endif
         case (state)
            ST_BOOT: begin
               state    <= ST_RUN;
               if_valid <= 1'b0;
            end
            ST_RUN: begin
               if (halt_req) begin
                  state    <= ST_HALT;
                  if_valid <= 1'b0;
               end else if (br_taken) begin
                  if_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
                  if (misaligned) begin
                     trap_q <= 1'b1;
                     state  <= ST_HALT;
                  end else begin
                     pc <= br_pc;
                  end
`else
                  pc <= br_pc;
`endif
               end else if (stall) begin
                  // Stall holds IF/ID; a concurrent flush still kills it.
                  if (flush) if_valid <= 1'b0;
               end else begin
                  pc          <= pc_plus4;
                  if_instr    <= instr_rd;
                  if_pc       <= pc;
                  if_pc_plus4 <= pc_plus4;
                  if_valid    <= ~flush;
               end
            end
            default: begin
               state    <= ST_HALT;
               if_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, straight-line fetch, stall, flush, redirect,
// wrap, misaligned redirect (both IFETCH_MISALIGN_TRAP_EN builds), halt and reset recovery.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        br_taken;
   logic [31:0] br_target;
   logic        halt_req;
   logic [31:0] pc_addr;
   logic [31:0] instr_rd;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        if_valid;
   logic        halted;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        misalign_trap;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      if (addr == 32'd0) return 32'h2002_0005;
      return 32'hE000_0000 ^ addr;
   endfunction

   assign instr_rd = mem_word(pc_addr);

   instr_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .halt_req    (halt_req),
      .pc_addr     (pc_addr),
      .instr_rd    (instr_rd),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .if_pc_plus4 (if_pc_plus4),
      .if_valid    (if_valid),
      .halted      (halted)
`ifdef IFETCH_MISALIGN_TRAP_EN
      ,
      .misalign_trap (misalign_trap)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall     = 1'b0;
      flush     = 1'b0;
      br_taken  = 1'b0;
      br_target = 32'd0;
      halt_req  = 1'b0;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] pc_e, input logic v_e);
      check({tag, "_if_pc"}, if_pc, pc_e);
      check({tag, "_if_instr"}, if_instr, mem_word(pc_e));
      check({tag, "_if_pc4"}, if_pc_plus4, pc_e + 32'd4);
      check({tag, "_if_valid"}, {31'd0, if_valid}, {31'd0, v_e});
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      check("rst_pc", pc_addr, 32'h0);
      check("rst_instr", if_instr, 32'h0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_pc4", if_pc_plus4, 32'h0);
      check("rst_valid", {31'd0, if_valid}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);

      // Boot cycle then first fetch
      reset = 1'b0;
      step();
      check("boot_valid", {31'd0, if_valid}, 32'd0);
      check("boot_pc", pc_addr, 32'h0);
      step();
      check("fetch0_instr", if_instr, 32'h2002_0005);
      check_ifid("fetch0", 32'h0, 1'b1);
      check("fetch0_pc", pc_addr, 32'h4);
      step();
      check("seq_pc8", pc_addr, 32'h8);
      check("seq_ifpc4", if_pc, 32'h4);
      step();
      check("seq_pcC", pc_addr, 32'hC);
      check("seq_ifpc8", if_pc, 32'h8);
      step();
      check("seq_pc10", pc_addr, 32'h10);
      check_ifid("seq_C", 32'hC, 1'b1);

      // Stall two cycles at PC 0x10
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_pc", pc_addr, 32'h10);
         check_ifid("stall", 32'hC, 1'b1);
      end
      stall = 1'b0;
      step();
      check("unstall_pc", pc_addr, 32'h14);
      check_ifid("unstall", 32'h10, 1'b1);

      // Flush: bubble, PC still advances
      flush = 1'b1;
      step();
      check("flush_pc", pc_addr, 32'h18);
      check("flush_valid", {31'd0, if_valid}, 32'd0);
      flush = 1'b0;
      step();
      check("postflush_pc", pc_addr, 32'h1C);
      check_ifid("postflush", 32'h18, 1'b1);

      // Redirect wins over stall
      stall = 1'b1; br_taken = 1'b1; br_target = 32'h40;
      step();
      check("br_stall_pc", pc_addr, 32'h40);
      check("br_stall_valid", {31'd0, if_valid}, 32'd0);
      idle_inputs();
      step();
      check_ifid("br_land", 32'h40, 1'b1);
      check("br_land_pc", pc_addr, 32'h44);

      // Wrap at top of address space
      br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
      step();
      check("wrap_br_pc", pc_addr, 32'hFFFF_FFFC);
      idle_inputs();
      step();
      check("wrap_pc", pc_addr, 32'h0);
      check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
      check("wrap_if_pc4", if_pc_plus4, 32'h0);
      step();
      check("wrap_next_pc", pc_addr, 32'h4);

      // Misaligned redirect target
      br_taken = 1'b1; br_target = 32'h42;
      step();
      idle_inputs();
`ifdef IFETCH_MISALIGN_TRAP_EN
      check("mis_trap", {31'd0, misalign_trap}, 32'd1);
      check("mis_halted", {31'd0, halted}, 32'd1);
      check("mis_pc", pc_addr, 32'h4);
      check("mis_valid", {31'd0, if_valid}, 32'd0);
      step();
      check("mis_trap_pulse", {31'd0, misalign_trap}, 32'd0);
      check("mis_still_halted", {31'd0, halted}, 32'd1);
`else
      check("mis_pc", pc_addr, 32'h40);
      check("mis_valid", {31'd0, if_valid}, 32'd0);
      step();
      check_ifid("mis_land", 32'h40, 1'b1);
`endif

      // Reset during stall + redirect
      reset = 1'b1; stall = 1'b1; br_taken = 1'b1; br_target = 32'h80;
      step();
      check("rst2_pc", pc_addr, 32'h0);
      check("rst2_valid", {31'd0, if_valid}, 32'd0);
      check("rst2_if_pc", if_pc, 32'h0);
      check("rst2_halted", {31'd0, halted}, 32'd0);
      reset = 1'b0; idle_inputs();
      step();
      step();
      check("rst2_fetch_pc", pc_addr, 32'h4);

      // Halt beats a same-cycle redirect
      br_taken = 1'b1; br_target = 32'h20;
      step();
      check("to20_pc", pc_addr, 32'h20);
      halt_req = 1'b1; br_target = 32'h80;
      step();
      check("halt_halted", {31'd0, halted}, 32'd1);
      check("halt_pc", pc_addr, 32'h20);
      check("halt_valid", {31'd0, if_valid}, 32'd0);
      halt_req = 1'b0; br_taken = 1'b1; br_target = 32'h100; flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stall = i[0];
         step();
         check("halt_hold_pc", pc_addr, 32'h20);
         check("halt_hold_halted", {31'd0, halted}, 32'd1);
         check("halt_hold_valid", {31'd0, if_valid}, 32'd0);
      end

      // Reset out of HALT
      reset = 1'b1;
      step();
      check("rst3_halted", {31'd0, halted}, 32'd0);
      check("rst3_pc", pc_addr, 32'h0);
      check("rst3_instr", if_instr, 32'h0);
      check("rst3_valid", {31'd0, if_valid}, 32'd0);
      reset = 1'b0; idle_inputs();
      step();
      step();
      check_ifid("rst3_fetch", 32'h0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
